seq_divider: RTL
================

Name: seq_divider

Overview:
- Sequential restoring divider; the inverse of the multiplier datapath.
- Takes an 8-bit product-width dividend and a 4-bit divisor. Returns quotient, remainder and a divide-by-zero flag.
- Sits beside the multiplier core behind the UART/SPI command front end, with valid/ready handshakes on both sides.
- Produces one quotient bit per clock.

Parameters:
- DIVIDEND_W, 8, dividend and quotient width; also the iteration count N.
- DIVISOR_W, 4, divisor and remainder width; must be ≤ DIVIDEND_W.

Ports:
- clk  input  1  system clock. One clock; reset is synchronous and active-high.
- rst  input  1  synchronous active-high reset.
- in_valid  input  1  operands valid.
- in_ready  output  1  block can accept operands.
- dividend  input  DIVIDEND_W  unsigned dividend.
- divisor  input  DIVISOR_W  unsigned divisor.
- out_valid  output  1  result valid.
- out_ready  input  1  consumer accepts result.
- quotient  output  DIVIDEND_W  unsigned quotient.
- remainder  output  DIVISOR_W  unsigned remainder.
- div_by_zero  output  1  divisor was zero.

Behaviour:
- States:
  - IDLE: in_ready=1.
  - CALC: in_ready=0, out_valid=0.
  - DONE: out_valid=1, in_ready=0.
- Reset: state IDLE. quotient, remainder, div_by_zero, out_valid and internal registers all 0. in_ready=0 while rst=1.
- IDLE→CALC on in_valid&in_ready with divisor≠0. Operands are latched on this edge (T0). Operand changes afterwards are ignored.
- Registers during CALC:
  - Q shift register (DIVIDEND_W), loaded with the dividend.
  - R partial remainder (DIVISOR_W+1), cleared to 0.
  - Step counter, 0..N-1.
- Each CALC cycle:
  - R' = {R[DIVISOR_W-1:0], Q[MSB]}; Q <<= 1.
  - If R' ≥ divisor: R' -= divisor and Q[0]=1; else Q[0]=0.
  - Comparison and subtraction are unsigned, DIVISOR_W+1 bits wide.
- CALC lasts exactly N edges (T1..TN), then →DONE. out_valid is first high in the cycle after TN, i.e. latency N+1 clocks from acceptance.
- quotient=Q and remainder=R[DIVISOR_W-1:0] are registered on entry to DONE. They are stable while out_valid=1.
- Divide by zero:
  - IDLE with divisor==0 and handshake → DONE directly (out_valid one cycle after acceptance).
  - quotient = all ones (0xFF), remainder=0, div_by_zero=1.
  - div_by_zero=0 for every non-zero divisor.
- DONE→IDLE on out_valid&out_ready.
  - Outputs keep their last values after the transfer; out_valid drops.
  - in_ready rises in the next cycle. No same-cycle accept of a new operation.
- Backpressure: out_ready low holds DONE indefinitely. Outputs and out_valid do not change.
- in_valid in CALC/DONE is ignored. No queuing.
- Reset in any state (including mid-CALC) aborts the operation and returns all outputs to reset values the next cycle.
- Boundary cases:
  - dividend < divisor gives quotient=0, remainder=dividend.
  - Dividend max with divisor 1 gives quotient=dividend, remainder=0.

Optional Feature:
- Macro: DIV_FAST_PATH_EN.
- Defined: at acceptance, divisor==1, or dividend < divisor with divisor≠0, bypasses CALC and goes straight to DONE one cycle after acceptance.
  - divisor==1: quotient=dividend, remainder=0.
  - dividend<divisor: quotient=0, remainder=dividend[DIVISOR_W-1:0].
  - Latency 1 for these cases; all other cases unchanged.
- Undefined: every non-zero divisor takes the full N-cycle CALC path. Latency is fixed at N+1; divide-by-zero stays at 1.

Test Plan:
- dividend=200, divisor=7, out_ready=1 → out_valid at cycle 9 after acceptance; quotient=28, remainder=4, div_by_zero=0; in_ready=1 one cycle after the transfer.
- dividend=225, divisor=15 → quotient=15, remainder=0. Then dividend=255, divisor=1 → quotient=255, remainder=0 (latency 9 without the macro, 1 with it).
- dividend=3, divisor=9 → quotient=0, remainder=3 (latency 9 without DIV_FAST_PATH_EN, 1 with it).
- dividend=100, divisor=0 → out_valid one cycle after acceptance; quotient=0xFF, remainder=0, div_by_zero=1.
- dividend=200, divisor=7 with out_ready held low 5 cycles after out_valid → outputs stable at 28/4, in_ready=0 throughout. Also toggle in_valid with new operands during CALC → ignored, result unchanged.
- Accept 200/7, assert rst at CALC cycle 4 → next cycle state IDLE, all outputs 0. Then 200/7 again → correct 28/4 with full latency.

Source files
------------

// File: rtl/seq_divider.sv
// Sequential restoring divider: one quotient bit per clock, valid/ready on both sides.
// Optional macro DIV_FAST_PATH_EN: divisor==1 or dividend<divisor completes one cycle after acceptance.
//
// state | meaning
// IDLE  | waiting for operands, in_ready=1
// CALC  | iterating, one quotient bit per clock
// DONE  | result held until out_ready
module seq_divider #(
  parameter int DIVIDEND_W = 8,
  parameter int DIVISOR_W  = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DIVIDEND_W-1:0] dividend,
  input  logic [DIVISOR_W-1:0]  divisor,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DIVIDEND_W-1:0] quotient,
  output logic [DIVISOR_W-1:0]  remainder,
  output logic                  div_by_zero
);

  localparam int CNT_W = (DIVIDEND_W > 1) ? $clog2(DIVIDEND_W) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(DIVIDEND_W - 1);

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t                state, state_nxt;
  logic [DIVIDEND_W-1:0] q_q;
  logic [DIVISOR_W-1:0]  r_q;
  logic [DIVISOR_W-1:0]  dvsr_q;
  logic [CNT_W-1:0]      cnt_q;

  logic                  accept;
  logic                  zero_in;
  logic                  fast_in;
  logic [DIVIDEND_W-1:0] fast_quot;
  logic [DIVISOR_W-1:0]  fast_rem;

  logic [DIVISOR_W:0]    r_shift;
  logic [DIVISOR_W:0]    r_diff;
  logic                  r_ge;
  logic [DIVISOR_W:0]    r_step;
  logic [DIVIDEND_W-1:0] q_step;

  assign in_ready  = (state == IDLE) && !rst;
  assign out_valid = (state == DONE);
  assign accept    = in_valid && in_ready;
  assign zero_in   = (divisor == '0);

`ifdef DIV_FAST_PATH_EN
  always_comb begin
    fast_in   = 1'b0;
    fast_quot = '0;
    fast_rem  = '0;
    if (divisor == DIVISOR_W'(1)) begin
      fast_in   = 1'b1;
      fast_quot = dividend;
    end else if (!zero_in && (dividend < DIVIDEND_W'(divisor))) begin
      fast_in   = 1'b1;
      fast_rem  = dividend[DIVISOR_W-1:0];
    end
  end
`else
  assign fast_in   = 1'b0;
  assign fast_quot = '0;
  assign fast_rem  = '0;
`endif

  // After each restoring step R < divisor, so only DIVISOR_W bits need storing;
  // the shift/compare/subtract still run DIVISOR_W+1 bits wide.
  always_comb begin
    r_shift = {r_q, q_q[DIVIDEND_W-1]};
    r_diff  = r_shift - {1'b0, dvsr_q};
    r_ge    = (r_shift >= {1'b0, dvsr_q});
    r_step  = r_ge ? r_diff : r_shift;
    q_step  = {q_q[DIVIDEND_W-2:0], r_ge};
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (accept) state_nxt = (zero_in || fast_in) ? DONE : CALC;
      CALC: if (cnt_q == '0) state_nxt = DONE;
      DONE: if (out_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      q_q         <= '0;
      r_q         <= '0;
      dvsr_q      <= '0;
      cnt_q       <= '0;
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            q_q    <= dividend;
            r_q    <= '0;
            dvsr_q <= divisor;
            cnt_q  <= LAST;
            if (zero_in) begin
              quotient    <= '1;
              remainder   <= '0;
              div_by_zero <= 1'b1;
            end else if (fast_in) begin
              quotient    <= fast_quot;
              remainder   <= fast_rem;
              div_by_zero <= 1'b0;
            end
          end
        end
        CALC: begin
          q_q   <= q_step;
          r_q   <= r_step[DIVISOR_W-1:0];
          cnt_q <= cnt_q - 1'b1;
          if (cnt_q == '0) begin
            quotient    <= q_step;
            remainder   <= r_step[DIVISOR_W-1:0];
            div_by_zero <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
